imem_load_ctrl: RTL

IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

---
 rtl/imem_load_ctrl.sv | 81 ++++++++
 1 files changed

// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: streams a program image into instruction RAM, then serves 1-cycle core fetches
module imem_load_ctrl #(
  parameter int          DEPTH = 1024,
  parameter int          AW    = 10,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  input  logic          fetch_req,
  input  logic [63:0]   fetch_pc,
  output logic [31:0]   instr,
  output logic          instr_valid,
  output logic          fetch_fault,
  output logic          core_hold,
  output logic [AW:0]   load_count,
  output logic          load_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  state_t      state, state_n;
  logic [AW:0] cnt, cnt_n;
  logic        err, err_n;
  logic        v, f;
  logic [31:0] hold;
  logic        ok, acc, fire, full;
  always_comb begin
    ok        = fetch_pc[1:0] == 2'b00 && fetch_pc[63:AW+2] == '0;
    full      = cnt == (AW+1)'(DEPTH - 1);
    ld_ready  = !reset && state == LOAD && cnt < (AW+1)'(DEPTH);
    acc       = ld_ready && ld_valid;
    fire      = !reset && state == RUN && !load_start && fetch_req;
    mem_en    = acc || (fire && ok);
    mem_we    = acc;
    mem_addr  = acc ? cnt[AW-1:0] : fetch_pc[AW+1:2];
    mem_wdata = ld_data;
    state_n   = state;
    cnt_n     = acc ? cnt + 1'b1 : cnt;
    err_n     = err;
    if (state != LOAD && load_start) begin
      state_n = LOAD;
      cnt_n   = '0;
      err_n   = 1'b0;
    end else if (acc && (ld_last || full)) begin
      state_n = RUN;
      err_n   = !ld_last;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      err   <= 1'b0;
      v     <= 1'b0;
      f     <= 1'b0;
      hold  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      err   <= err_n;
      v     <= fire;
      f     <= fire && !ok;
      if (v) hold <= instr;
    end
  end
  // read data arrives straight from the RAM in the delivery cycle; hold keeps it stable afterwards
  assign instr       = v ? (f ? NOP : mem_rdata) : hold;
  assign instr_valid = v;
  assign fetch_fault = v && f;
  assign core_hold   = state != RUN;
  assign load_count  = cnt;
  assign load_err    = err;
endmodule
